// File: rtl/mem_scan_reader_if.sv
// Write port, scan control/status and the valid/ready output stream of mem_scan_reader.
// The master side drives writes, scan requests and out_ready. The slave side is the reader.
interface mem_scan_reader_if #(
    parameter int WIDTH  = 18,
    parameter int ADDR_W = 11
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              start;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              busy;
    logic              done;
    logic              err;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [WIDTH-1:0]  out_data;
    logic              out_last;
    logic [WIDTH-1:0]  checksum;

    modport master (
        output wr_en, wr_addr, wr_data, start, first_addr, last_addr, out_ready,
        input  busy, done, err, out_valid, out_addr, out_data, out_last, checksum
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, first_addr, last_addr, out_ready,
        output busy, done, err, out_valid, out_addr, out_data, out_last, checksum
    );
endinterface

// File: rtl/mem_scan_reader.sv
// Memory bank with a write port and a scan engine that streams an address range with a running checksum.
// First word 2 cycles after start accept, then 1 word/cycle; out_ready low stalls reads via a 2-entry buffer.
module mem_scan_reader #(
    parameter int WIDTH  = 18,
    parameter int DEPTH  = 1718,
    parameter int ADDR_W = 11
) (
    input  logic           clk,
    input  logic           reset,
    mem_scan_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0] bank [DEPTH];

    state_t            state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] last_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [WIDTH-1:0]  checksum_q;

    // Read issued last cycle; its data sits in rd_data this cycle.
    logic              pend;
    logic              pend_last;
    logic [ADDR_W-1:0] pend_addr;
    logic [WIDTH-1:0]  rd_data;

    // Buffer head (presented on the stream) and second slot.
    logic              head_vld;
    logic              head_last;
    logic [ADDR_W-1:0] head_addr;
    logic [WIDTH-1:0]  head_dat;
    logic              skid_vld;
    logic              skid_last;
    logic [ADDR_W-1:0] skid_addr;
    logic [WIDTH-1:0]  skid_dat;

    logic       pop;
    logic       rd_en;
    logic       start_ok;
    logic [1:0] used;

    // A read is counted against buffer room the moment it is issued, so it always has a slot to land in.
    always_comb begin
        pop      = head_vld & bus.out_ready;
        used     = 2'(head_vld) + 2'(skid_vld) + 2'(pend) - 2'(pop);
        rd_en    = (state == SCAN) && (used < 2'd2);
        start_ok = (bus.first_addr <= MAX_ADDR) && (bus.last_addr <= MAX_ADDR);
    end

    // Nonblocking read and write on the same edge give read-before-write.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (bus.wr_addr <= MAX_ADDR))
            bank[bus.wr_addr] <= bus.wr_data;
        if (rd_en)
            rd_data <= bank[rd_ptr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            last_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            checksum_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (pop)
                checksum_q <= checksum_q + head_dat;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (start_ok) begin
                            rd_ptr     <= bus.first_addr;
                            last_q     <= bus.last_addr;
                            checksum_q <= '0;
                            busy_q     <= 1'b1;
                            state      <= SCAN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (rd_en) begin
                        rd_ptr <= (rd_ptr == MAX_ADDR) ? '0 : rd_ptr + 1'b1;
                        if (rd_ptr == last_q)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && head_last) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FINISH;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend      <= 1'b0;
            pend_last <= 1'b0;
            pend_addr <= '0;
            head_vld  <= 1'b0;
            head_last <= 1'b0;
            head_addr <= '0;
            head_dat  <= '0;
            skid_vld  <= 1'b0;
            skid_last <= 1'b0;
            skid_addr <= '0;
            skid_dat  <= '0;
        end else begin
            pend <= rd_en;
            if (rd_en) begin
                pend_addr <= rd_ptr;
                pend_last <= (rd_ptr == last_q);
            end
            if (!head_vld || pop) begin
                if (skid_vld) begin
                    head_vld  <= 1'b1;
                    head_last <= skid_last;
                    head_addr <= skid_addr;
                    head_dat  <= skid_dat;
                    skid_vld  <= pend;
                    if (pend) begin
                        skid_last <= pend_last;
                        skid_addr <= pend_addr;
                        skid_dat  <= rd_data;
                    end
                end else if (pend) begin
                    head_vld  <= 1'b1;
                    head_last <= pend_last;
                    head_addr <= pend_addr;
                    head_dat  <= rd_data;
                end else begin
                    head_vld  <= 1'b0;
                    head_last <= 1'b0;
                end
            end else if (pend) begin
                skid_vld  <= 1'b1;
                skid_last <= pend_last;
                skid_addr <= pend_addr;
                skid_dat  <= rd_data;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.out_valid = head_vld;
    assign bus.out_addr  = head_addr;
    assign bus.out_data  = head_dat;
    assign bus.out_last  = head_last;
    assign bus.checksum  = checksum_q;
endmodule

// File: tb/tb_mem_scan_reader.sv
// Scoreboard bench for mem_scan_reader: expected words are queued at start and checked per handshake.
module tb_mem_scan_reader;
    localparam int WIDTH  = 18;
    localparam int DEPTH  = 1718;
    localparam int ADDR_W = 11;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [WIDTH-1:0]  d;
        logic              l;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    mem_scan_reader_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    mem_scan_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] mem [DEPTH];
    exp_t sb[$];
    exp_t e;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;
    int   hs_n, hs_first, hs_last;
    logic rdy_rand = 1'b0;
    logic stall_prev = 1'b0;
    logic [ADDR_W+WIDTH:0] stall_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a scan and queue the words it must produce, using bank contents as of start time.
    task automatic scan(input int first, input int last);
        int a;
        tick();
        bus.start      = 1'b1;
        bus.first_addr = ADDR_W'(first);
        bus.last_addr  = ADDR_W'(last);
        a = first;
        forever begin
            sb.push_back('{a: ADDR_W'(a), d: mem[a], l: (a == last)});
            if (a == last) break;
            a = (a == DEPTH - 1) ? 0 : a + 1;
        end
        hs_n = 0;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int n, input int ck, input bit tput);
        int  t;
        bit  seen;
        t = 0;
        seen = 0;
        while (!seen && t < 3000) begin
            @(negedge clk);
            t++;
            if (bus.done) seen = 1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("busy_at_done", 32'(bus.busy), 32'd0);
            chk("word_count", hs_n, n);
            chk("checksum", 32'(bus.checksum), ck);
            chk("sb_empty", sb.size(), 0);
            if (tput) chk("no_bubbles", hs_last - hs_first, n - 1);
            @(negedge clk);
            chk("done_one_cycle", 32'(bus.done), 32'd0);
            chk("checksum_hold", 32'(bus.checksum), ck);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_stable", 32'({bus.out_last, bus.out_addr, bus.out_data}), 32'(stall_word));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_word", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("out_addr", 32'(bus.out_addr), 32'(e.a));
                    chk("out_data", 32'(bus.out_data), 32'(e.d));
                    chk("out_last", 32'(bus.out_last), 32'(e.l));
                    if (hs_n == 0) hs_first = cyc;
                    hs_last = cyc;
                    hs_n++;
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            stall_word = {bus.out_last, bus.out_addr, bus.out_data};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int dn;
        reset          = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.start      = 1'b0;
        bus.first_addr = '0;
        bus.last_addr  = '0;
        bus.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_last", 32'(bus.out_last), 0);
        chk("rst_addr", 32'(bus.out_addr), 0);
        chk("rst_data", 32'(bus.out_data), 0);
        chk("rst_checksum", 32'(bus.checksum), 0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            tick();
            bus.wr_en   = 1'b1;
            bus.wr_addr = ADDR_W'(i);
            bus.wr_data = WIDTH'(i);
            mem[i]      = WIDTH'(i);
        end
        tick();
        bus.wr_en = 1'b0;

        // Basic scan with latency check
        scan(0, 3);
        chk("busy_after_start", 32'(bus.busy), 1);
        @(negedge clk);
        chk("lat_cycle1_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        chk("lat_cycle2_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        chk("lat_first_valid", 32'(bus.out_valid), 1);
        wait_done(4, 6, 1);

        scan(1716, 1);
        wait_done(4, 3434, 1);

        rdy_rand = 1'b1;
        scan(0, 15);
        wait_done(16, 120, 0);
        rdy_rand = 1'b0;
        tick();
        bus.out_ready = 1'b1;

        // Out-of-range start
        tick();
        bus.start      = 1'b1;
        bus.first_addr = ADDR_W'(1718);
        bus.last_addr  = ADDR_W'(5);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("err_pulse", 32'(bus.err), 1);
        chk("err_busy", 32'(bus.busy), 0);
        chk("err_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        chk("err_one_cycle", 32'(bus.err), 0);
        chk("err_done", 32'(bus.done), 0);
        chk("err_busy2", 32'(bus.busy), 0);

        scan(175, 175);
        wait_done(1, 175, 1);

        // Start while busy is ignored
        scan(0, 99);
        repeat (10) tick();
        bus.start      = 1'b1;
        bus.first_addr = ADDR_W'(5);
        bus.last_addr  = ADDR_W'(6);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("busy_start_err", 32'(bus.err), 0);
        wait_done(100, 4950, 1);

        // Write to 44 on the cycle its read is issued: stream must show old data
        scan(40, 50);
        repeat (4) @(posedge clk);
        #1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = ADDR_W'(44);
        bus.wr_data = 18'h3FFFF;
        tick();
        bus.wr_en = 1'b0;
        mem[44]   = 18'h3FFFF;
        wait_done(11, 495, 1);
        scan(44, 44);
        wait_done(1, 32'h3FFFF, 1);

        // Reset mid-scan
        scan(0, 19);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_addr", 32'(bus.out_addr), 0);
        chk("mid_rst_data", 32'(bus.out_data), 0);
        chk("mid_rst_last", 32'(bus.out_last), 0);
        chk("mid_rst_checksum", 32'(bus.checksum), 0);
        sb.delete();
        repeat (2) tick();
        reset = 1'b0;
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("no_done_after_rst", dn, 0);
        chk("idle_after_rst", 32'(bus.busy), 0);

        scan(0, 3);
        wait_done(4, 6, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mem_scan_reader.md
Name: mem_scan_reader

Overview:
- Synthesizable single-port-write / scan-read memory bank. Software or testbench loads it through a write port.
- A scan engine reads an address range back and streams each word out over a valid/ready interface, with a running checksum.
- Acts as the front-door reader for banks that are filled by write traffic. It sits between a memory bank and a downstream consumer or checker.

Parameters:
- WIDTH, 18: data word width in bits.
- DEPTH, 1718: number of words; legal addresses 0..DEPTH-1.
- ADDR_W, 11: address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  WIDTH  write data.
- start  input  1  scan request, single-cycle pulse.
- first_addr  input  ADDR_W  first scan address, sampled with start.
- last_addr  input  ADDR_W  last scan address, inclusive, sampled with start.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse after the final word handshakes.
- err  output  1  one-cycle pulse on a rejected start.
- out_valid  output  1  stream word valid.
- out_ready  input  1  consumer accepts word.
- out_addr  output  ADDR_W  address of the presented word.
- out_data  output  WIDTH  presented word.
- out_last  output  1  presented word is the final word of the scan.
- checksum  output  WIDTH  sum of accepted words mod 2^WIDTH.

Behaviour:
- Reset values:
  - busy, done, err, out_valid, out_last = 0.
  - out_addr, out_data, checksum = 0.
  - FSM returns to IDLE.
  - Memory array is not cleared.
- Writes: when wr_en=1, bank[wr_addr] <= wr_data at the edge. Writes with wr_addr >= DEPTH are dropped. Writes are accepted in every state.
- Reads are synchronous, one-cycle latency, read-before-write. A same-cycle write to the address being read returns the old data; the new data is visible on the next read.
- FSM states: IDLE, SCAN, DRAIN, FINISH.
- IDLE:
  - start=1 with first_addr<DEPTH and last_addr<DEPTH: latch the range, clear checksum, set busy=1, go to SCAN.
  - start=1 with either address >= DEPTH: err=1 for one cycle, stay in IDLE, busy stays 0.
- SCAN:
  - Issue one read per cycle while the internal 2-entry output buffer has room, counting in-flight reads.
  - Read pointer increments; after DEPTH-1 it wraps to 0.
  - If last_addr < first_addr, the scan wraps: first..DEPTH-1, then 0..last.
  - After the read of last_addr is issued, go to DRAIN.
- DRAIN: wait until the buffer is empty and the out_last word has handshaked, then go to FINISH.
- FINISH: done=1 and busy=0 for one cycle, then go to IDLE.
- Output stream:
  - Driven from the head of the 2-entry buffer.
  - out_valid holds and out_addr/out_data/out_last stay stable until out_ready=1.
  - Handshake occurs when out_valid && out_ready.
  - With out_ready held high: first out_valid appears 2 cycles after the start-accept edge, and throughput is 1 word per cycle with no bubbles.
  - No word is dropped or duplicated under any out_ready pattern.
  - out_last=1 only on the word at last_addr.
- Checksum: on each handshake, checksum <= checksum + out_data, truncated to WIDTH. It holds its value after done until the next accepted start.
- first_addr == last_addr: exactly one word is streamed, with out_last=1.
- start while busy is ignored: no err, range unchanged.
- Reset asserted mid-scan: outputs immediately go to their reset values, and the scan is abandoned with no done pulse.

Test Plan:
- Preload bank[i]=i for all i. Scan first=0, last=3 with out_ready=1 -> out_data 0,1,2,3 on consecutive cycles; first valid 2 cycles after start; out_last only on addr 3; done pulse; checksum=6.
- Wrap scan first=1716, last=1 -> out_addr 1716,1717,0,1; checksum=3434; out_last on addr 1.
- Scan 0..15 with out_ready pseudo-random at about 50% -> all 16 words in order, each exactly once; data stable while stalled; checksum=120.
- start with first_addr=1718 -> err pulse for 1 cycle; busy, out_valid and done stay 0. A later legal start succeeds.
- first=last=175 -> a single word 175 with out_last=1; checksum=175. Then a start during a 0..99 scan is ignored and exactly 100 words result.
- Mid-scan (after 5 words), write bank[44]=0x3FFFF in the same cycle its read is issued -> the stream shows 44; a rescan of 44 shows 0x3FFFF. Assert reset during the next scan -> all outputs 0 asynchronously, no done, and the next scan works normally.
